// File: rtl/sccb_config_master.sv
// +----------------------------------------------------------------------------+
// | sccb_config_master: streams {reg,value} table entries to an SCCB sensor    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sccb_config_master #(
  parameter int         CLK_DIV    = 68,
  parameter logic [7:0] DEVICE_ID  = 8'h60,
  parameter int         RESET_WAIT = 27000,
  parameter int         GAP_WAIT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        resend,
  output logic        advance,
  input  logic        reconfig,
  output logic        sioc,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        busy,
  output logic        done,
  output logic        nack
);

  localparam int QW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_MAX = (RESET_WAIT > GAP_WAIT) ? RESET_WAIT : GAP_WAIT;
  localparam int WW       = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_REWIND = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_BITS   = 3'd3,
    S_STOP   = 3'd4,
    S_POST   = 3'd5,
    S_ADV    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t        state;
  logic [QW-1:0] qdiv;
  logic [1:0]    quarter;
  logic [4:0]    bit_idx;
  logic [26:0]   shreg;
  logic [15:0]   cmd_q;
  logic [1:0]    fetch_cnt;
  logic [WW-1:0] wait_cnt;
  logic          tick;
  logic          ack_slot;

  assign tick     = (qdiv == QW'(CLK_DIV - 1));
  assign ack_slot = (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_REWIND;
      sioc      <= 1'b1;
      siod_oe   <= 1'b0;
      resend    <= 1'b0;
      advance   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      qdiv      <= '0;
      quarter   <= 2'd0;
      bit_idx   <= 5'd0;
      shreg     <= '0;
      cmd_q     <= '0;
      fetch_cnt <= 2'd0;
      wait_cnt  <= '0;
    end else begin
      resend  <= 1'b0;
      advance <= 1'b0;
      if (state == S_START || state == S_BITS || state == S_STOP)
        qdiv <= tick ? '0 : qdiv + QW'(1);

      case (state)
        S_REWIND: begin
          resend    <= 1'b1;
          busy      <= 1'b1;
          done      <= 1'b0;
          nack      <= 1'b0;
          fetch_cnt <= 2'd0;
          state     <= S_FETCH;
        end

        // Table output lags the pulse by two registers
        S_FETCH: begin
          if (fetch_cnt == 2'd2) begin
            if (finished) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              cmd_q   <= command;
              // Ack slots carry a 1 so the line is released there
              shreg   <= {DEVICE_ID, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
              qdiv    <= '0;
              quarter <= 2'd0;
              state   <= S_START;
            end
          end else begin
            fetch_cnt <= fetch_cnt + 2'd1;
          end
        end

        S_START: begin
          if (tick) begin
            if (quarter == 2'd3) begin
              quarter <= 2'd0;
              bit_idx <= 5'd0;
              sioc    <= 1'b0;
              siod_oe <= ~shreg[26];
              state   <= S_BITS;
            end else begin
              quarter <= quarter + 2'd1;
              if (quarter == 2'd1)
                siod_oe <= 1'b1;
            end
          end
        end

        S_BITS: begin
          if (tick) begin
            case (quarter)
              2'd1: begin
                sioc <= 1'b1;
                if (ack_slot && siod_in)
                  nack <= 1'b1;
              end
              2'd3: begin
                sioc <= 1'b0;
                if (bit_idx == 5'd26) begin
                  siod_oe <= 1'b1;
                  state   <= S_STOP;
                end else begin
                  bit_idx <= bit_idx + 5'd1;
                  shreg   <= {shreg[25:0], 1'b0};
                  siod_oe <= ~shreg[25];
                end
              end
              default: ;
            endcase
            quarter <= quarter + 2'd1;
          end
        end

        S_STOP: begin
          if (tick) begin
            quarter <= quarter + 2'd1;
            case (quarter)
              2'd0: sioc    <= 1'b1;
              2'd2: siod_oe <= 1'b0;
              2'd3: begin
                wait_cnt <= (cmd_q == 16'h1280) ? WW'(RESET_WAIT - 1) : WW'(GAP_WAIT - 1);
                state    <= S_POST;
              end
              default: ;
            endcase
          end
        end

        S_POST: begin
          if (wait_cnt == '0)
            state <= S_ADV;
          else
            wait_cnt <= wait_cnt - WW'(1);
        end

        S_ADV: begin
          advance   <= 1'b1;
          fetch_cnt <= 2'd0;
          state     <= S_FETCH;
        end

        S_DONE: begin
          if (reconfig)
            state <= S_REWIND;
        end

        default: state <= S_REWIND;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sccb_config_master.sv
// Bench for sccb_config_master: table model, SCCB bus decoder/slave, vector + random runs.
`timescale 1ns/1ps
`default_nettype none

module tb_sccb_config_master;

  localparam int CLK_DIV    = 4;
  localparam int RESET_WAIT = 200;
  localparam int GAP_WAIT   = 8;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        reconfig = 1'b0;
  logic [15:0] command  = 16'h0000;
  logic        finished = 1'b0;
  logic        siod_in;
  logic        resend, advance, sioc, siod_oe, busy, done, nack;

  always #5 clk = ~clk;

  sccb_config_master #(
    .CLK_DIV   (CLK_DIV),
    .DEVICE_ID (8'h60),
    .RESET_WAIT(RESET_WAIT),
    .GAP_WAIT  (GAP_WAIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .command (command),
    .finished(finished),
    .resend  (resend),
    .advance (advance),
    .reconfig(reconfig),
    .sioc    (sioc),
    .siod_oe (siod_oe),
    .siod_in (siod_in),
    .busy    (busy),
    .done    (done),
    .nack    (nack)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input longint act, input longint lo);
    checks++;
    if (act < lo) begin
      failures++;
      $display("FAIL %s actual=%0d required_min=%0d", name, act, lo);
    end
  endtask

  // ---------------- register table model: address reg, then command reg
  logic [3:0][15:0] tcmds = '1;
  int               addr  = 0;

  function automatic logic [15:0] entry(input int a);
    return (a >= 0 && a < 4) ? tcmds[a] : 16'hFFFF;
  endfunction

  always @(posedge clk) begin
    if (resend)       addr <= 0;
    else if (advance) addr <= addr + 1;
    command  <= entry(addr);
    finished <= (entry(addr) == 16'hFFFF);
  end

  // ---------------- bus monitor / decoder / slave
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          mon_en = 1'b0;
  int          clear_req = 0, clear_ack = 0;
  int          nack_txn = 0;
  bit          in_txn = 1'b0;
  int          nbits = 0, txn_idx = 0, adv_cnt = 0, res_cnt = 0, sioc_falls = 0;
  int          fall_cyc = 0, release_cyc = 0, last_rise = 0;
  bit          have_release = 1'b0, last_reset = 1'b0;
  logic        prev_sioc = 1'b1, prev_oe = 1'b0, prev_adv = 1'b0, prev_res = 1'b0;
  logic [26:0] bits = '0;
  logic [23:0] txq[$];

  // Slave acks low, except in ack slots of the selected transaction
  assign siod_in = (in_txn && (nbits % 9 == 8)) ? (txn_idx == nack_txn) : ~siod_oe;

  always @(negedge clk) begin
    if (clear_req != clear_ack) begin
      clear_ack    = clear_req;
      in_txn       = 1'b0;
      nbits        = 0;
      txn_idx      = 0;
      adv_cnt      = 0;
      res_cnt      = 0;
      sioc_falls   = 0;
      have_release = 1'b0;
      txq.delete();
      prev_sioc    = sioc;
      prev_oe      = siod_oe;
      prev_adv     = 1'b0;
      prev_res     = 1'b0;
    end
    if (mon_en) begin
      chk("pulse_exclusive", resend & advance, 0);
      chk("advance_width", advance & prev_adv, 0);
      chk("resend_width", resend & prev_res, 0);
      if (advance) adv_cnt++;
      if (resend)  res_cnt++;
      if (!sioc && prev_sioc) sioc_falls++;
      if (siod_oe != prev_oe && sioc) begin
        chk("siod_not_at_sioc_rise", prev_sioc, 1);
        if (siod_oe) begin
          chk("start_when_idle", in_txn, 0);
          if (have_release)
            chk_ge("gap_before_start", cyc - release_cyc,
                   last_reset ? RESET_WAIT + 2 : GAP_WAIT + 2);
          in_txn = 1'b1; nbits = 0; bits = '0; fall_cyc = cyc; txn_idx++;
        end else begin
          chk("stop_bit_count", nbits, 27);
          // start fall at START q2 .. release at STOP q3 = 116 - 3 quarters
          chk("start_to_release", cyc - fall_cyc, 113 * CLK_DIV);
          txq.push_back({bits[26:19], bits[17:10], bits[8:1]});
          last_reset   = ({bits[17:10], bits[8:1]} == 16'h1280);
          in_txn       = 1'b0;
          release_cyc  = cyc;
          have_release = 1'b1;
        end
      end
      if (sioc && !prev_sioc && in_txn && nbits < 27) begin
        bits = {bits[25:0], siod_in};
        if (nbits > 0) chk("sioc_period", cyc - last_rise, 4 * CLK_DIV);
        last_rise = cyc;
        nbits++;
        if (nbits % 9 == 0)
          chk("nack_at_ack", nack, (nack_txn != 0 && txn_idx >= nack_txn) ? 1 : 0);
      end
      prev_sioc = sioc;
      prev_oe   = siod_oe;
      prev_adv  = advance;
      prev_res  = resend;
    end
  end

  // ---------------- vectors
  typedef struct {
    logic [3:0][15:0] cmds;
    int               nack_txn;
    int               exp_adv;
    bit               exp_nack;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] c0, c1, c2, c3,
                              input int nt, input int ea, input bit en);
    vec_t v;
    v.cmds[0] = c0; v.cmds[1] = c1; v.cmds[2] = c2; v.cmds[3] = c3;
    v.nack_txn = nt; v.exp_adv = ea; v.exp_nack = en;
    return v;
  endfunction

  task automatic mon_clear();
    clear_req++;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_sioc", sioc, 1);
    chk("rst_siod_oe", siod_oe, 0);
    chk("rst_resend", resend, 0);
    chk("rst_advance", advance, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    mon_clear();
    mon_en = 1'b1;
    rst_n  = 1'b1;
    @(posedge clk); #2;
    chk("resend_first_cycle", resend, 1);
    chk("busy_after_resend", busy, 1);
  endtask

  task automatic wait_done(output int ncyc);
    ncyc = 0;
    while (!done && ncyc < 30000) begin
      @(posedge clk); #2;
      ncyc++;
    end
    chk("done_reached", done, 1);
  endtask

  // Reference: one {ID, reg, value} write per entry before the first FFFF
  task automatic check_result(input vec_t v);
    int n = 0;
    while (n < 4 && v.cmds[n] != 16'hFFFF) n++;
    repeat (2) @(posedge clk);
    #2;
    chk("txn_count", txq.size(), n);
    for (int i = 0; i < n && i < txq.size(); i++)
      chk("txn_bytes", txq[i], {8'h60, v.cmds[i]});
    chk("advance_count", adv_cnt, v.exp_adv);
    chk("resend_count", res_cnt, 1);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_nack", nack, v.exp_nack);
    chk("end_sioc", sioc, 1);
    chk("end_siod_oe", siod_oe, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int nc;
    tcmds    = v.cmds;
    nack_txn = v.nack_txn;
    do_reset();
    wait_done(nc);
    if (v.exp_adv == 0) begin
      chk("empty_done_latency_le5", (nc + 1 <= 5) ? 1 : 0, 1);
      chk("empty_no_sioc_toggle", sioc_falls, 0);
    end
    check_result(v);
  endtask

  vec_t vecs[4];

  initial begin
    int   nc;
    vec_t rv;
    int   len;

    vecs[0] = mk(16'hFF01, 16'h1280, 16'h0A5A, 16'hFFFF, 0, 3, 1'b0);
    vecs[1] = mk(16'hFF01, 16'h1280, 16'h0A5A, 16'hFFFF, 2, 3, 1'b1);
    vecs[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 1'b0);
    vecs[3] = mk(16'h1280, 16'hFFFF, 16'h1111, 16'h2222, 1, 1, 1'b1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // randomized tables
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        if (i < len) begin
          rv.cmds[i] = ($urandom_range(0, 3) == 0) ? 16'h1280 : 16'($urandom);
          if (rv.cmds[i] == 16'hFFFF) rv.cmds[i] = 16'h0000;
        end else begin
          rv.cmds[i] = 16'hFFFF;
        end
      end
      rv.nack_txn = $urandom_range(0, len);
      rv.exp_adv  = len;
      rv.exp_nack = (rv.nack_txn != 0);
      run_vec(rv);
    end

    // reconfig while busy is ignored
    tcmds    = vecs[1].cmds;
    nack_txn = 2;
    do_reset();
    repeat (300) @(posedge clk);
    #2 reconfig = 1'b1;
    @(posedge clk); #2 reconfig = 1'b0;
    repeat (700) @(posedge clk);
    #2 reconfig = 1'b1;
    @(posedge clk); #2 reconfig = 1'b0;
    wait_done(nc);
    check_result(vecs[1]);

    // reconfig in DONE repeats the sequence with nack cleared
    nack_txn = 0;
    mon_clear();
    reconfig = 1'b1;
    @(posedge clk); #2 reconfig = 1'b0;
    @(posedge clk); #2;
    chk("reconfig_resend", resend, 1);
    chk("reconfig_nack_cleared", nack, 0);
    chk("reconfig_busy", busy, 1);
    wait_done(nc);
    check_result(vecs[0]);

    // reset mid-BITS
    tcmds    = vecs[0].cmds;
    nack_txn = 0;
    do_reset();
    nc = 0;
    while (!(in_txn && nbits >= 5) && nc < 5000) begin
      @(posedge clk); #2;
      nc++;
    end
    chk("reached_mid_bits", (in_txn && nbits >= 5) ? 1 : 0, 1);
    chk("mid_bits_sioc_low_phase_or_high", busy, 1);
    rst_n  = 1'b0;
    mon_en = 1'b0;
    @(posedge clk); #2;
    chk("midrst_sioc", sioc, 1);
    chk("midrst_siod_oe", siod_oe, 0);
    chk("midrst_busy", busy, 0);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
